// File: rtl/branch_redirect_ctrl.sv
// E-stage control-transfer handling: decodes branches/jumps, issues PC redirects,
// tracks the delay slot, and keeps running CTI / taken-CTI counters.
module branch_redirect_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        validE,
    input  logic [5:0]  opcodeE,
    input  logic [5:0]  functE,
    input  logic        branchE,
    input  logic [31:0] branchTargetE,
    input  logic [31:0] jumpTargetE,
    input  logic [31:0] regTargetE,
    input  logic        redirectReady,
    input  logic        cntClear,
    output logic        redirectValid,
    output logic [31:0] redirectPC,
    output logic        stallReq,
    output logic        inDelaySlot,
    output logic        dsError,
    output logic [31:0] branchCount,
    output logic [31:0] takenCount
);

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_JALR   = 6'h09;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DS   = 2'd2
    } stateT;

    stateT       state;
    stateT       nextState;

    logic        advance;
    logic        isCond;
    logic        isJump;
    logic        isRegJump;
    logic        isCti;
    logic        taken;
    logic [31:0] ctiTarget;
    logic [31:0] holdPC;
    logic [31:0] branchCnt;
    logic [31:0] takenCnt;
    logic        countCti;
    logic        countTaken;
    logic        latchHold;
    logic        dsViolation;

    assign advance = validE && !stall;

    // The rt field is not visible here, so every REGIMM opcode is treated as BLTZ/BGEZ.
    always_comb begin
        isCond    = 1'b0;
        isJump    = 1'b0;
        isRegJump = 1'b0;
        case (opcodeE)
            OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: isCond = 1'b1;
            OP_J, OP_JAL:                                isJump = 1'b1;
            OP_RTYPE: isRegJump = (functE == FN_JR) || (functE == FN_JALR);
            default: ;
        endcase
    end

    assign isCti = isCond || isJump || isRegJump;
    assign taken = (isCond && branchE) || isJump || isRegJump;

    always_comb begin
        ctiTarget = 32'h0;
        if (isCond)
            ctiTarget = branchTargetE;
        else if (isJump)
            ctiTarget = jumpTargetE;
        else if (isRegJump)
            ctiTarget = regTargetE;
    end

    assign countCti    = (state == IDLE) && advance && isCti;
    assign countTaken  = countCti && taken;
    assign latchHold   = countTaken && !redirectReady;
    assign dsViolation = (state == DS) && advance && isCti;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (advance && isCti)
                    nextState = (taken && !redirectReady) ? PEND : DS;
            end
            PEND: begin
                if (redirectReady)
                    nextState = DS;
            end
            DS: begin
                if (advance)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // redirectPC is forced to zero whenever no redirect is being offered.
    always_comb begin
        redirectValid = 1'b0;
        redirectPC    = 32'h0;
        stallReq      = 1'b0;
        inDelaySlot   = 1'b0;
        case (state)
            IDLE: begin
                if (countTaken) begin
                    redirectValid = 1'b1;
                    redirectPC    = ctiTarget;
                end
            end
            PEND: begin
                redirectValid = 1'b1;
                redirectPC    = holdPC;
                stallReq      = 1'b1;
            end
            DS: begin
                inDelaySlot = 1'b1;
            end
            default: ;
        endcase
    end

    // Counter clear beats a same-cycle increment; dsError only clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            holdPC    <= 32'h0;
            dsError   <= 1'b0;
            branchCnt <= 32'h0;
            takenCnt  <= 32'h0;
        end else begin
            if (latchHold)
                holdPC <= ctiTarget;
            if (dsViolation)
                dsError <= 1'b1;
            if (cntClear) begin
                branchCnt <= 32'h0;
                takenCnt  <= 32'h0;
            end else begin
                if (countCti)
                    branchCnt <= branchCnt + 32'd1;
                if (countTaken)
                    takenCnt <= takenCnt + 32'd1;
            end
        end
    end

    assign branchCount = branchCnt;
    assign takenCount  = takenCnt;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Table-driven bench for branch_redirect_ctrl: one row per clock cycle, outputs
// compared mid-cycle against hand-computed values, plus PEND / wrap / reset sequences.
module tb_branch_redirect_ctrl;

    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] RT     = 6'h00;
    localparam logic [5:0] REGIMM = 6'h01;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] JAL    = 6'h03;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] BLEZ   = 6'h06;
    localparam logic [5:0] BGTZ   = 6'h07;
    localparam logic [5:0] ADD    = 6'h20;
    localparam logic [5:0] JR     = 6'h08;
    localparam logic [5:0] JALR   = 6'h09;

    localparam logic [31:0] BT = 32'h0000_0040;
    localparam logic [31:0] JT = 32'h0000_2000;
    localparam logic [31:0] RG = 32'h0000_1000;

    typedef struct {
        logic        rst;
        logic        v;
        logic        st;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        br;
        logic        rdy;
        logic        clr;
        logic        rv;
        logic [31:0] pc;
        logic        sr;
        logic        ds;
        logic        err;
        logic [31:0] bc;
        logic [31:0] tc;
    } vecT;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        validE;
    logic [5:0]  opcodeE;
    logic [5:0]  functE;
    logic        branchE;
    logic [31:0] branchTargetE;
    logic [31:0] jumpTargetE;
    logic [31:0] regTargetE;
    logic        redirectReady;
    logic        cntClear;
    logic        redirectValid;
    logic [31:0] redirectPC;
    logic        stallReq;
    logic        inDelaySlot;
    logic        dsError;
    logic [31:0] branchCount;
    logic [31:0] takenCount;

    int checks   = 0;
    int failures = 0;
    vecT vecs[$];

    branch_redirect_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .validE        (validE),
        .opcodeE       (opcodeE),
        .functE        (functE),
        .branchE       (branchE),
        .branchTargetE (branchTargetE),
        .jumpTargetE   (jumpTargetE),
        .regTargetE    (regTargetE),
        .redirectReady (redirectReady),
        .cntClear      (cntClear),
        .redirectValid (redirectValid),
        .redirectPC    (redirectPC),
        .stallReq      (stallReq),
        .inDelaySlot   (inDelaySlot),
        .dsError       (dsError),
        .branchCount   (branchCount),
        .takenCount    (takenCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] timeout");
    end

    function automatic vecT mk(input logic r, input logic v, input logic st,
                               input logic [5:0] op, input logic [5:0] fn,
                               input logic br, input logic rdy, input logic clr,
                               input logic rv, input logic [31:0] pc, input logic sr,
                               input logic ds, input logic err,
                               input logic [31:0] bc, input logic [31:0] tc);
        vecT t;
        t.rst = r;   t.v = v;     t.st = st;  t.op = op;  t.fn = fn;
        t.br = br;   t.rdy = rdy; t.clr = clr;
        t.rv = rv;   t.pc = pc;   t.sr = sr;  t.ds = ds;  t.err = err;
        t.bc = bc;   t.tc = tc;
        return t;
    endfunction

    task automatic checkVal(input string name, input string tag, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s %s[%0d] actual=%h required=%h", name, tag, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vecT t);
        rst           = t.rst;
        validE        = t.v;
        stall         = t.st;
        opcodeE       = t.op;
        functE        = t.fn;
        branchE       = t.br;
        redirectReady = t.rdy;
        cntClear      = t.clr;
    endtask

    task automatic checkOutput(input string tag, input int idx, input vecT t);
        checkVal("redirectValid", tag, idx, {31'h0, redirectValid}, {31'h0, t.rv});
        checkVal("redirectPC",    tag, idx, redirectPC,             t.pc);
        checkVal("stallReq",      tag, idx, {31'h0, stallReq},      {31'h0, t.sr});
        checkVal("inDelaySlot",   tag, idx, {31'h0, inDelaySlot},   {31'h0, t.ds});
        checkVal("dsError",       tag, idx, {31'h0, dsError},       {31'h0, t.err});
        checkVal("branchCount",   tag, idx, branchCount,            t.bc);
        checkVal("takenCount",    tag, idx, takenCount,             t.tc);
    endtask

    // Drive at the falling edge, sample 1ns later, then let the rising edge commit.
    task automatic runCycle(input string tag, input int idx, input vecT t);
        applyStimulus(t);
        #1;
        checkOutput(tag, idx, t);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; validE = 1'b0; opcodeE = LW; functE = 6'h0;
        branchE = 1'b0; redirectReady = 1'b0; cntClear = 1'b0;
        branchTargetE = BT; jumpTargetE = JT; regTargetE = RG;

        //               rst v  st op      fn    br rdy clr  rv pc  sr ds err bc tc
        vecs.push_back(mk(1, 0, 0, LW,     0,    0, 0, 0,   0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, LW,     0,    0, 0, 0,   0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, LW,     0,    0, 0, 0,   0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, BEQ,    0,    1, 1, 0,   1, BT, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, LW,     0,    0, 1, 0,   0, 0,  0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, RT,     ADD,  0, 1, 0,   0, 0,  0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, BNE,    0,    0, 1, 0,   0, 0,  0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, RT,     ADD,  0, 1, 0,   0, 0,  0, 1, 0, 2, 1));
        vecs.push_back(mk(0, 1, 0, RT,     ADD,  0, 1, 0,   0, 0,  0, 1, 0, 2, 1));
        vecs.push_back(mk(0, 1, 0, J,      0,    0, 1, 0,   1, JT, 0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 1, 0, JAL,    0,    0, 1, 0,   0, 0,  0, 1, 0, 3, 2));
        vecs.push_back(mk(0, 0, 0, LW,     0,    0, 1, 0,   0, 0,  0, 0, 1, 3, 2));
        vecs.push_back(mk(0, 1, 1, BLEZ,   0,    1, 1, 0,   0, 0,  0, 0, 1, 3, 2));
        vecs.push_back(mk(0, 1, 0, BLEZ,   0,    1, 1, 0,   1, BT, 0, 0, 1, 3, 2));
        vecs.push_back(mk(0, 1, 0, LW,     0,    0, 1, 0,   0, 0,  0, 1, 1, 4, 3));
        vecs.push_back(mk(0, 1, 0, BGTZ,   0,    0, 1, 0,   0, 0,  0, 0, 1, 4, 3));
        vecs.push_back(mk(0, 1, 0, RT,     ADD,  0, 1, 1,   0, 0,  0, 1, 1, 5, 3));
        vecs.push_back(mk(0, 1, 0, REGIMM, 0,    1, 1, 0,   1, BT, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, RT,     ADD,  0, 1, 0,   0, 0,  0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, RT,     JALR, 0, 1, 0,   1, RG, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, LW,     0,    0, 1, 0,   0, 0,  0, 1, 1, 2, 2));
        vecs.push_back(mk(0, 1, 0, JAL,    0,    0, 0, 0,   1, JT, 0, 0, 1, 2, 2));
        vecs.push_back(mk(0, 1, 0, BEQ,    0,    1, 0, 0,   1, JT, 1, 0, 1, 3, 3));
        vecs.push_back(mk(0, 1, 0, BEQ,    0,    1, 1, 0,   1, JT, 1, 0, 1, 3, 3));
        vecs.push_back(mk(0, 0, 0, LW,     0,    0, 1, 0,   0, 0,  0, 1, 1, 3, 3));
        vecs.push_back(mk(1, 1, 0, BEQ,    0,    1, 1, 0,   0, 0,  0, 1, 1, 3, 3));
        vecs.push_back(mk(0, 0, 0, LW,     0,    0, 1, 0,   0, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, BEQ,    0,    1, 1, 1,   1, BT, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, LW,     0,    0, 1, 0,   0, 0,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, RT,     ADD,  0, 1, 0,   0, 0,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, LW,     0,    0, 0, 0,   0, 0,  0, 0, 0, 0, 0));

        repeat (2) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++)
            runCycle("table", i, vecs[i]);

        // JR held in PEND for three not-ready cycles; the held target must ignore regTargetE.
        runCycle("pend", 0, mk(0, 1, 0, RT, JR, 0, 0, 0,  1, RG, 0, 0, 0, 0, 0));
        regTargetE = 32'h0000_5555;
        runCycle("pend", 1, mk(0, 1, 0, RT, JR, 0, 0, 0,  1, RG, 1, 0, 0, 1, 1));
        runCycle("pend", 2, mk(0, 1, 0, RT, JR, 0, 0, 0,  1, RG, 1, 0, 0, 1, 1));
        runCycle("pend", 3, mk(0, 1, 0, RT, JR, 0, 1, 0,  1, RG, 1, 0, 0, 1, 1));
        regTargetE = RG;
        runCycle("pend", 4, mk(0, 0, 0, LW, 0,  0, 0, 0,  0, 0,  0, 1, 0, 1, 1));
        runCycle("pend", 5, mk(0, 1, 0, RT, ADD, 0, 1, 0, 0, 0,  0, 1, 0, 1, 1));

        // Preset both counters to all-ones, then a taken branch must wrap both to zero.
        force dut.branchCnt = 32'hFFFF_FFFF;
        force dut.takenCnt  = 32'hFFFF_FFFF;
        #1;
        release dut.branchCnt;
        release dut.takenCnt;
        runCycle("wrap", 0, mk(0, 1, 0, BEQ, 0, 1, 1, 0,  1, BT, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        runCycle("wrap", 1, mk(0, 0, 0, LW,  0, 0, 1, 0,  0, 0,  0, 1, 0, 0, 0));
        runCycle("wrap", 2, mk(0, 1, 0, RT, ADD, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0));

        // Reset while in PEND drops the redirect and stall request on the next cycle.
        runCycle("rstpend", 0, mk(0, 1, 0, JAL, 0, 0, 0, 0,  1, JT, 0, 0, 0, 0, 0));
        runCycle("rstpend", 1, mk(1, 0, 0, LW,  0, 0, 0, 0,  1, JT, 1, 0, 0, 1, 1));
        runCycle("rstpend", 2, mk(0, 0, 0, LW,  0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0));
        runCycle("rstpend", 3, mk(0, 0, 0, LW,  0, 0, 1, 0,  0, 0,  0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
